branch_pc_unit: RTL and testbench

//  Registered program-counter and branch-resolution unit for the single-issue core.

---
 rtl/branch_pc_unit.sv | 116 +++++++++++
 tb/tb_branch_pc_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution: six compare conditions plus JUMP, redirect with flush window.
// Optional BRANCH_STATS_EN adds saturating branch/redirect counters; otherwise both stats outputs read 0.
module branch_pc_unit #(
  parameter int              XLEN         = 32,
  parameter int              IMM_W        = 16,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              PC_STEP      = 4,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [2:0]       branch_op,
  input  logic [XLEN-1:0]  reg1,
  input  logic [XLEN-1:0]  reg2,
  input  logic [IMM_W-1:0] imm,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_next_seq,
  output logic [XLEN-1:0]  target,
  output logic             zero,
  output logic             taken,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
  localparam logic [3:0]      FLUSH_LD = 4'(FLUSH_CYCLES);

  state_t           state;
  logic [3:0]       flush_cnt;
  logic [XLEN-1:0]  offset;
  logic             cond;
  logic             commit;

  assign offset      = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} << 2;
  assign pc_next_seq = pc + STEP;
  assign target      = pc_next_seq + offset;
  assign zero        = (reg1 == reg2);

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      3'b000:  cond = zero;
      3'b001:  cond = !zero;
      3'b010:  cond = ($signed(reg1) <  $signed(reg2));
      3'b011:  cond = ($signed(reg1) >= $signed(reg2));
      3'b100:  cond = (reg1 <  reg2);
      3'b101:  cond = (reg1 >= reg2);
      3'b110:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = branch_valid & cond & (state == RUN);
  assign commit = !stall;

  // Commit edge: PC update and flush-window FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= RUN;
      flush     <= 1'b0;
      flush_cnt <= '0;
    end else if (commit) begin
      pc <= taken ? target : pc_next_seq;
      case (state)
        RUN: begin
          if (taken) begin
            state     <= FLUSH;
            flush     <= 1'b1;
            flush_cnt <= FLUSH_LD;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd1) begin
            state     <= RUN;
            flush     <= 1'b0;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Commit edge: statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (commit) begin
      if (branch_valid && state == RUN) branch_cnt <= sat_inc(branch_cnt);
      if (taken)                        taken_cnt  <= sat_inc(taken_cnt);
    end
  end
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Randomized and directed bench for branch_pc_unit against a cycle-level reference model.
module tb_branch_pc_unit;

  localparam int          FLUSH_N  = 3;
  localparam logic [31:0] RST_PC   = 32'h100;
`ifdef BRANCH_STATS_EN
  localparam int          CNT_MAX  = 15;
  localparam bit          STATS    = 1'b1;
`else
  localparam int          CNT_MAX  = 15;
  localparam bit          STATS    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [2:0]  branch_op = 3'd0;
  logic [31:0] reg1 = '0, reg2 = '0;
  logic [15:0] imm = '0;
  logic [31:0] pc, pc_next_seq, target;
  logic        zero, taken, flush;
  logic [3:0]  branch_cnt, taken_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_fl;
  int          m_bc, m_tc;

  branch_pc_unit #(
    .XLEN(32), .IMM_W(16), .RESET_PC(RST_PC), .PC_STEP(4),
    .FLUSH_CYCLES(FLUSH_N), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_op(branch_op), .reg1(reg1), .reg2(reg2), .imm(imm),
    .pc(pc), .pc_next_seq(pc_next_seq), .target(target), .zero(zero),
    .taken(taken), .flush(flush), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return int'(a) <  int'(b);
      3'd3: return int'(a) >= int'(b);
      3'd4: return longint'({32'd0, a}) <  longint'({32'd0, b});
      3'd5: return longint'({32'd0, a}) >= longint'({32'd0, b});
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [15:0] i);
    return p + 32'd4 + 32'(int'($signed(i)) * 4);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_fl = 0;
    m_bc = 0;
    m_tc = 0;
  endtask

  // entered at posedge+1 with inputs set; returns at the next posedge+1
  task automatic run_cycle();
    bit          exp_tk;
    bit          acc;
    logic [31:0] exp_tg;
    #2;
    exp_tk = branch_valid && ref_cond(branch_op, reg1, reg2) && (m_fl == 0);
    exp_tg = ref_target(m_pc, imm);
    check("pc", pc, m_pc);
    check("pc_next_seq", pc_next_seq, m_pc + 32'd4);
    check("target", target, exp_tg);
    check("zero", 32'(zero), 32'(reg1 == reg2));
    check("taken", 32'(taken), 32'(exp_tk));
    check("flush", 32'(flush), 32'(m_fl > 0));
    check("branch_cnt", 32'(branch_cnt), STATS ? 32'(m_bc) : 32'd0);
    check("taken_cnt", 32'(taken_cnt), STATS ? 32'(m_tc) : 32'd0);
    @(posedge clk);
    #1;
    if (!stall) begin
      acc  = branch_valid && (m_fl == 0);
      m_pc = exp_tk ? exp_tg : m_pc + 32'd4;
      if (m_fl > 0) m_fl--;
      else if (exp_tk) m_fl = FLUSH_N;
      if (acc && m_bc < CNT_MAX) m_bc++;
      if (exp_tk && m_tc < CNT_MAX) m_tc++;
    end
  endtask

  task automatic drain();
    branch_valid = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 20 && m_fl > 0; i++) run_cycle();
  endtask

  // redirect so that pc equals addr once the flush window has drained
  task automatic jump_to(input logic [31:0] addr);
    logic [31:0] tgt;
    tgt = addr - 32'(4 * FLUSH_N);
    stall = 1'b0;
    branch_valid = 1'b1;
    branch_op = 3'd6;
    imm = 16'((int'(tgt) - int'(m_pc + 32'd4)) / 4);
    run_cycle();
    drain();
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, RST_PC);
    check("async_rst_flush", 32'(flush), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [2:0]  ops3 [5];
  logic        exp3 [5];
  logic [31:0] saved;

  initial begin
    // asynchronous reset between clock edges
    #13 rst = 1'b1;
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_flush", 32'(flush), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_cycle();

    // BEQ backward branch from 0x40
    jump_to(32'h40);
    check("t2_pc_start", pc, 32'h40);
    branch_valid = 1'b1; branch_op = 3'd0; reg1 = 32'd5; reg2 = 32'd5; imm = 16'hFFFE;
    #1;
    check("t2_zero", 32'(zero), 32'd1);
    check("t2_taken", 32'(taken), 32'd1);
    check("t2_target", target, 32'h3C);
    run_cycle();
    check("t2_pc_redirect", pc, 32'h3C);
    check("t2_flush_rise", 32'(flush), 32'd1);
    branch_valid = 1'b0;
    run_cycle();
    check("t2_pc_after", pc, 32'h40);
    drain();

    // signed vs unsigned compare, evaluated while stalled
    ops3 = '{3'd2, 3'd4, 3'd3, 3'd5, 3'd7};
    exp3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    stall = 1'b1; branch_valid = 1'b1; reg1 = 32'hFFFF_FFFF; reg2 = 32'd1;
    for (int k = 0; k < 5; k++) begin
      branch_op = ops3[k];
      #1;
      check($sformatf("t3_taken_op%0d", ops3[k]), 32'(taken), 32'(exp3[k]));
      run_cycle();
    end

    // taken BNE held under stall, then released
    saved = m_pc;
    branch_op = 3'd1; reg1 = 32'd1; reg2 = 32'd2; imm = 16'd8;
    for (int k = 0; k < 3; k++) run_cycle();
    check("t4_pc_held", pc, saved);
    check("t4_flush_held", 32'(flush), 32'd0);
    stall = 1'b0;
    run_cycle();
    check("t4_pc_redirect", pc, saved + 32'd36);
    check("t4_flush", 32'(flush), 32'd1);
    drain();

    // PC wrap, branch ignored in flush, reset mid-flush
    jump_to(32'hFFFF_FFFC);
    branch_valid = 1'b0;
    run_cycle();
    check("t5_wrap", pc, 32'h0);
    branch_valid = 1'b1; branch_op = 3'd6; imm = 16'd5;
    run_cycle();
    #1;
    check("t5_taken_in_flush", 32'(taken), 32'd0);
    run_cycle();
    check("t5_flush_before_rst", 32'(flush), 32'd1);
    branch_valid = 1'b0;
    reset_mid();
    run_cycle();

    // counter saturation with back-to-back JUMPs
    branch_valid = 1'b1; branch_op = 3'd6; imm = 16'd0; stall = 1'b0;
    for (int k = 0; k < 80; k++) run_cycle();
    check("t6_taken_cnt", 32'(taken_cnt), STATS ? 32'hF : 32'h0);
    check("t6_branch_cnt", 32'(branch_cnt), STATS ? 32'hF : 32'h0);
    drain();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      branch_valid = ($urandom_range(0, 3) != 0);
      branch_op    = 3'($urandom_range(0, 7));
      reg1         = $urandom;
      reg2         = ($urandom_range(0, 3) == 0) ? reg1 : $urandom;
      imm          = 16'($urandom);
      stall        = ($urandom_range(0, 3) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
